// File: rtl/pkt_accum_pkg.sv
// Shared types and constants for the packet accumulator controller.
// The optional saturation build (macro PKT_ACCUM_SAT_EN) is selected in acc_adder.
package pkt_accum_pkg;

  localparam int BYTES_PER_PKT = 4;
  localparam int SUM_W         = 10;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
    RAM_RD,
    RAM_CAPT,
    RAM_WR
  } state_t;

endpackage

// File: rtl/acc_adder.sv
// Combinational adder that folds a packet sum into a RAM word.
// Define PKT_ACCUM_SAT_EN to clamp at all-ones; otherwise the result wraps.
module acc_adder
  import pkt_accum_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] base,
  input  logic [SUM_W-1:0]  addend,
  output logic [DATA_W-1:0] total
);

`ifdef PKT_ACCUM_SAT_EN
  // One extra bit catches the carry that triggers the clamp.
  logic [DATA_W:0] raw;

  assign raw   = {1'b0, base} + {{(DATA_W + 1 - SUM_W){1'b0}}, addend};
  assign total = raw[DATA_W] ? {DATA_W{1'b1}} : raw[DATA_W-1:0];
`else
  assign total = base + {{(DATA_W - SUM_W){1'b0}}, addend};
`endif

endmodule

// File: rtl/pkt_accum_ctrl.sv
// Sums four FIFO bytes per packet and adds the sum into a RAM slot (read-modify-write).
// Result wraps by default; build with PKT_ACCUM_SAT_EN for a saturating result.
module pkt_accum_ctrl
  import pkt_accum_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_rdata,
  output logic              rd_fifo,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              pkt_done
);

  state_t            state;
  state_t            state_next;
  logic [SUM_W-1:0]  sum;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] adder_out;

  always_ff @(posedge clk_2) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Every packet byte returns through IDLE, so bytes are never popped back to back.
  always_comb begin
    state_next = state;
    rd_fifo    = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      IDLE:     if (!fifo_empty) state_next = POP;
      POP: begin
        rd_fifo    = 1'b1;
        state_next = CAPT;
      end
      CAPT:     state_next = (byte_cnt == 2'(BYTES_PER_PKT - 1)) ? RAM_RD : IDLE;
      RAM_RD: begin
        ram_rd     = 1'b1;
        state_next = RAM_CAPT;
      end
      RAM_CAPT: state_next = RAM_WR;
      RAM_WR: begin
        ram_wr     = 1'b1;
        pkt_done   = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  acc_adder #(
    .DATA_W (DATA_W)
  ) u_acc_adder (
    .base   (ram_rdata),
    .addend (sum),
    .total  (adder_out)
  );

  // wdata_q doubles as the result register, so ram_wdata holds between writes.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sum      <= '0;
      byte_cnt <= '0;
      addr_cnt <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        CAPT: begin
          sum      <= sum + {2'b00, fifo_rdata};
          byte_cnt <= byte_cnt + 2'd1;
        end
        RAM_CAPT: wdata_q <= adder_out;
        RAM_WR: begin
          sum      <= '0;
          byte_cnt <= '0;
          addr_cnt <= addr_cnt + {{(ADDR_W - 1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  assign ram_addr  = addr_cnt;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_pkt_accum_ctrl.sv
// Directed bench for pkt_accum_ctrl with FIFO and RAM models; ADDR_W=2 so slot wrap is short.
// Expected saturation result follows PKT_ACCUM_SAT_EN.
module tb_pkt_accum_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 16;
`ifdef PKT_ACCUM_SAT_EN
  localparam logic [DATA_W-1:0] EXP_SAT = 16'hFFFF;
`else
  localparam logic [DATA_W-1:0] EXP_SAT = 16'h0010;
`endif

  logic              clk_2 = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata = 8'h00;
  logic              rd_fifo;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_wdata;
  logic              pkt_done;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk_2 = ~clk_2;

  pkt_accum_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rd_fifo    (rd_fifo),
    .ram_rdata  (ram_rdata),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_wdata  (ram_wdata),
    .pkt_done   (pkt_done)
  );

  logic [7:0] fifoMem [0:255];
  int wrPtr = 0;
  int rdPtr = 0;
  assign fifo_empty = (wrPtr == rdPtr);

  always @(posedge clk_2) begin
    if (rd_fifo && (rdPtr != wrPtr)) begin
      fifo_rdata <= fifoMem[rdPtr[7:0]];
      rdPtr      <= rdPtr + 1;
    end
  end

  // RAM model clears on reset; ovrEn forces a fixed read value for directed cases.
  logic [DATA_W-1:0] mem [0:3];
  logic              ovrEn  = 1'b1;
  logic [DATA_W-1:0] ovrVal = '0;

  always @(posedge clk_2) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_rd) ram_rdata <= ovrEn ? ovrVal : mem[ram_addr];
  end

  logic [ADDR_W-1:0] wrAddr [0:31];
  logic [DATA_W-1:0] wrData [0:31];
  logic [DATA_W-1:0] prevWdata = '0;
  int wrCount = 0;
  int viol    = 0;

  always @(negedge clk_2) begin
    if (ram_wr && wrCount < 32) begin
      wrAddr[wrCount] = ram_addr;
      wrData[wrCount] = ram_wdata;
    end
    if (ram_wr) wrCount++;
    if ((ram_rd && ram_wr) || (rd_fifo && (ram_rd || ram_wr)) || (pkt_done !== ram_wr)) viol++;
    if (!reset && !ram_wr && (ram_wdata !== prevWdata)) viol++;
    prevWdata = ram_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifoMem[wrPtr[7:0]] = b;
    wrPtr++;
  endtask

  task automatic pushPacket(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    applyStimulus(b0);
    applyStimulus(b1);
    applyStimulus(b2);
    applyStimulus(b3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic doReset(input int n);
    @(negedge clk_2);
    reset = 1'b1;
    repeat (n) @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc, output int cycles);
    cycles = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      @(negedge clk_2);
      if (pkt_done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int base;
    int strobes;
    logic found;

    $display("[TB] start");
    idle(3);
    checkOutput("reset_strobes", {28'd0, rd_fifo, ram_rd, ram_wr, pkt_done}, 32'd0);
    checkOutput("reset_wdata", ram_wdata, 32'd0);
    checkOutput("reset_addr", ram_addr, 32'd0);

    // Bytes queued during reset: first RAM_WR lands 14 edges after release.
    pushPacket(8'h01, 8'h02, 8'h03, 8'h04);
    reset = 1'b0;
    waitDone(40, cyc);
    checkOutput("pkt1_latency", cyc, 32'd14);
    idle(2);
    checkOutput("pkt1_wrcount", wrCount, 32'd1);
    checkOutput("pkt1_addr", wrAddr[0], 32'd0);
    checkOutput("pkt1_data", wrData[0], 32'd10);
    checkOutput("pkt1_addr_next", ram_addr, 32'd1);
    checkOutput("pkt1_wdata_hold", ram_wdata, 32'd10);

    doReset(2);
    ovrEn = 1'b0;
    base  = wrCount;
    pushPacket(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pushPacket(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    waitDone(40, cyc);
    checkOutput("ff_pkt1_seen", (cyc > 0) ? 32'd1 : 32'd0, 32'd1);
    waitDone(40, cyc);
    checkOutput("ff_pkt2_gap", cyc, 32'd15);
    idle(2);
    checkOutput("ff_wrcount", wrCount - base, 32'd2);
    checkOutput("ff_addr0", wrAddr[base], 32'd0);
    checkOutput("ff_data0", wrData[base], 32'd1020);
    checkOutput("ff_addr1", wrAddr[base+1], 32'd1);
    checkOutput("ff_data1", wrData[base+1], 32'd1020);

    // Slots 2 and 3, then the wrap back to slot 0, which already holds 1020.
    pushPacket(8'h01, 8'h01, 8'h01, 8'h01);
    pushPacket(8'h01, 8'h01, 8'h01, 8'h01);
    pushPacket(8'h10, 8'h20, 8'h30, 8'h40);
    for (int k = 0; k < 3; k++) begin
      waitDone(40, cyc);
      checkOutput("wrap_done", (cyc > 0) ? 32'd1 : 32'd0, 32'd1);
    end
    idle(2);
    checkOutput("wrap_addr2", wrAddr[base+2], 32'd2);
    checkOutput("wrap_data2", wrData[base+2], 32'd4);
    checkOutput("wrap_addr3", wrAddr[base+3], 32'd3);
    checkOutput("wrap_addr5", wrAddr[base+4], 32'd0);
    checkOutput("wrap_data5", wrData[base+4], 32'd1180);

    doReset(2);
    ovrEn  = 1'b1;
    ovrVal = 16'hFFF0;
    base   = wrCount;
    pushPacket(8'h08, 8'h08, 8'h08, 8'h08);
    waitDone(40, cyc);
    idle(2);
    checkOutput("sat_wrcount", wrCount - base, 32'd1);
    checkOutput("sat_data", wrData[base], EXP_SAT);

    doReset(2);
    ovrVal = '0;
    base   = wrCount;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    idle(10);
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_2);
      if (rd_fifo || ram_rd || ram_wr || pkt_done) strobes++;
    end
    checkOutput("starve_strobes", strobes, 32'd0);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    waitDone(30, cyc);
    checkOutput("starve_latency", cyc, 32'd8);
    idle(2);
    checkOutput("starve_wrcount", wrCount - base, 32'd1);
    checkOutput("starve_addr", wrAddr[base], 32'd0);
    checkOutput("starve_data", wrData[base], 32'h00AA);

    doReset(2);
    ovrEn = 1'b0;
    pushPacket(8'h50, 8'h50, 8'h50, 8'h50);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_2);
      if (ram_rd === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rstcapt_rd_seen", {31'd0, found}, 32'd1);
    @(negedge clk_2);
    base  = wrCount;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(3);
    checkOutput("rstcapt_no_wr", wrCount - base, 32'd0);
    pushPacket(8'h01, 8'h02, 8'h03, 8'h04);
    waitDone(40, cyc);
    idle(2);
    checkOutput("rstcapt_wrcount", wrCount - base, 32'd1);
    checkOutput("rstcapt_addr", wrAddr[base], 32'd0);
    checkOutput("rstcapt_data", wrData[base], 32'd10);

    checkOutput("protocol_violations", viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
